// File: rtl/register_store_unit_pkg.sv
// Shared definitions for the register store path: widths, beat count and store FSM encoding.
package register_store_unit_pkg;

    localparam int RSU_WORD      = 16;
    localparam int RSU_MEM_WIDTH = 8;
    localparam int RSU_ADDR      = 16;
    localparam int RSU_TIMEOUT   = 15;

    function automatic int beats_of(input int word, input int mem_width);
        return word / mem_width;
    endfunction

    localparam int RSU_BEATS = beats_of(RSU_WORD, RSU_MEM_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } store_state_e;

endpackage

// File: rtl/register_store_unit_if.sv
// Narrow memory write bus: one beat per mem_we/mem_ack handshake.
interface register_store_unit_if
    import register_store_unit_pkg::*;
#(
    parameter int ADDR      = RSU_ADDR,
    parameter int MEM_WIDTH = RSU_MEM_WIDTH
) ();

    logic [ADDR-1:0]      mem_addr;
    logic [MEM_WIDTH-1:0] mem_wdata;
    logic                 mem_we;
    logic                 mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ack
    );

endinterface

// File: rtl/register_store_unit_store_wait_timer.sv
// Per-beat wait counter; expire is high in the last cycle a beat may wait without mem_ack.
module store_wait_timer
    import register_store_unit_pkg::*;
#(
    parameter int TIMEOUT = RSU_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || !run) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The edge that ends this cycle would be the TIMEOUT-th one without an ack.
    assign expire = run && !clear && (count_q == LAST);

endmodule

// File: rtl/register_store_unit.sv
// Stores a WORD-wide register value to a narrow memory bus as little-endian beats.
// Define STORE_TIMEOUT_EN to abort a beat that waits TIMEOUT cycles for mem_ack.
module register_store_unit
    import register_store_unit_pkg::*;
#(
    parameter int WORD      = RSU_WORD,
    parameter int MEM_WIDTH = RSU_MEM_WIDTH,
    parameter int ADDR      = RSU_ADDR,
    parameter int TIMEOUT   = RSU_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD-1:0]       value,
    input  logic [ADDR-1:0]       addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    register_store_unit_if.master mem
);

    localparam int BEATS  = beats_of(WORD, MEM_WIDTH);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((WORD % MEM_WIDTH) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("register_store_unit: WORD must be a multiple of MEM_WIDTH and TIMEOUT >= 1");
    end

    store_state_e         state_q;
    logic [WORD-1:0]      value_q;
    logic [ADDR-1:0]      addr_q;
    logic [BEAT_W-1:0]    beat_q;
    logic [ADDR-1:0]      mem_addr_q;
    logic [MEM_WIDTH-1:0] mem_wdata_q;
    logic                 mem_we_q;
    logic                 busy_q;
    logic                 done_q;

    logic [MEM_WIDTH-1:0] slice [BEATS];
    logic [BEAT_W-1:0]    beat_d;
    logic [ADDR-1:0]      mem_addr_d;

    genvar gi;
    for (gi = 0; gi < BEATS; gi++) begin : g_slice
        assign slice[gi] = value_q[gi*MEM_WIDTH +: MEM_WIDTH];
    end

    // Address wraps naturally at 2^ADDR through the fixed-width add.
    assign beat_d     = beat_q + BEAT_W'(1);
    assign mem_addr_d = addr_q + ADDR'(beat_d);

`ifdef STORE_TIMEOUT_EN
    logic err_q;
    logic timer_expire;

    store_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == WRITE),
        .clear  (mem.mem_ack),
        .expire (timer_expire)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            value_q     <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef STORE_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        value_q     <= value;
                        addr_q      <= addr;
                        mem_addr_q  <= addr;
                        mem_wdata_q <= value[MEM_WIDTH-1:0];
                        mem_we_q    <= 1'b1;
                        beat_q      <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        if (beat_q == LAST_BEAT) begin
                            mem_we_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            beat_q      <= beat_d;
                            mem_addr_q  <= mem_addr_d;
                            mem_wdata_q <= slice[beat_d];
                        end
                    end
`ifdef STORE_TIMEOUT_EN
                    else if (timer_expire) begin
                        mem_we_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ABORT;
                    end
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;

endmodule

// File: doc/register_store_unit.md
Name: register_store_unit

Overview:
- Write-back counterpart of the CPU's register load path: takes a WORD-wide register value and a target address, and stores it to the narrow memory bus.
- Splits the word into MEM_WIDTH beats, little-endian.
- Each beat uses a req/ack handshake.
- Sits between the register bank and the memory interface; driven by the control unit's store command.

Parameters:
- WORD, 16, register data width; must be an integer multiple of MEM_WIDTH.
- MEM_WIDTH, 8, memory data bus width per beat.
- ADDR, 16, memory address width.
- TIMEOUT, 15, max cycles waiting for mem_ack per beat; used only with STORE_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle store request from the control unit.
- value  in  WORD  register value to store; sampled when start is accepted.
- addr  in  ADDR  base byte address; sampled when start is accepted.
- busy  out  1  high while a store is in progress (state != IDLE).
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout abort; constant 0 without STORE_TIMEOUT_EN.
- mem_addr  out  ADDR  beat address.
- mem_wdata  out  MEM_WIDTH  beat data.
- mem_we  out  1  write request, held high until acknowledged.
- mem_ack  in  1  memory accepts the current beat in this cycle.

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0; beat counter=0; captured value/addr=0.
- Reset has priority over every other event. Reset mid-store drops mem_we on the next edge; the partial store is abandoned, with no done and no err.
- BEATS = WORD/MEM_WIDTH.
- States:
  - IDLE -> WRITE when start=1. The edge captures value and addr, and loads mem_addr=addr and mem_wdata=value[MEM_WIDTH-1:0]. mem_we=1 and beat=0.
  - WRITE: mem_we held high; mem_addr/mem_wdata stable until mem_ack.
    - On an edge with mem_ack=1 and beat<BEATS-1: beat++. mem_addr=captured addr+beat+1, taken mod 2^ADDR so it wraps from 0xFFFF to 0x0000. mem_wdata=next slice value[(beat+1)*MEM_WIDTH +: MEM_WIDTH]. mem_we stays 1, so back-to-back beats are allowed.
    - On an edge with mem_ack=1 and beat=BEATS-1: mem_we=0, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1 during it, then IDLE.
- Latency: start at cycle 0; first beat presented in cycle 1. With mem_ack tied high, the last beat is in cycle BEATS and done is in cycle BEATS+1. The earliest next start is accepted in cycle BEATS+2 (state back in IDLE).
- start while busy=1 (including DONE) is ignored; no queuing.
- mem_ack while mem_we=0 is ignored.
- value/addr changes after acceptance have no effect.
- BEATS=1 (WORD=MEM_WIDTH) is legal: single-beat WRITE, then DONE.

Optional Feature:
- STORE_TIMEOUT_EN defined:
  - Per-beat wait counter runs in WRITE; it clears on reset, on each mem_ack and on entry to WRITE.
  - When the counter reaches TIMEOUT with no mem_ack, go to ABORT: mem_we=0 on that edge.
  - ABORT: err=1 for one cycle, busy=1, then IDLE. done is not pulsed.
- Not defined: no counter, no ABORT state, err tied 0; WRITE waits indefinitely.

Decomposition:
- Shared package, alongside the existing word-width definitions:
  - state encoding IDLE/WRITE/DONE/ABORT;
  - BEATS constant derived from WORD and MEM_WIDTH;
  - default TIMEOUT.
- One natural sub-module: store_wait_timer (counter, clear, expire flag), instantiated only under STORE_TIMEOUT_EN.
- Beat slicing and address increment stay inline.

Test Plan:
1. WORD=16, MEM_WIDTH=8, mem_ack tied 1, start with value=0xBEEF, addr=0x0100 -> cycle 1 {0x0100,0xEF,we=1}, cycle 2 {0x0101,0xBE,we=1}, done in cycle 3, busy 0 in cycle 4.
2. mem_ack delayed 3 cycles per beat, value=0x1234, addr=0x0040 -> mem_addr/mem_wdata stable while waiting; writes 0x34@0x0040 then 0x12@0x0041; a single done pulse.
3. addr=0xFFFF, value=0xA55A -> beats 0x5A@0xFFFF, 0xA5@0x0000.
4. Second start during WRITE and during DONE, with value=0x0000 -> ignored; memory holds only the first store's bytes; exactly one done.
5. reset asserted with mem_ack=0 during beat 1 -> next edge has mem_we=0, busy=0, all outputs at reset values; no done; a new start afterwards completes normally.
6. STORE_TIMEOUT_EN, TIMEOUT=15, mem_ack never asserted -> mem_we high for 15 cycles, then 0; err pulses one cycle; done never asserted; back in IDLE. Without the macro, err stays 0 and mem_we stays high.
